// File: rtl/cnn_pkg.sv
// Shared constants and types for the small CNN convolution blocks.
// Holds the default widths, the map/kernel geometry and the FSM state encoding.
package cnn_pkg;

  localparam int IN_W_DEF  = 4;
  localparam int W_W_DEF   = 4;
  localparam int ACC_W_DEF = 13;

  localparam int MAP_IN  = 12;
  localparam int MAP_OUT = 8;
  localparam int KER     = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/conv_5x5_mac.sv
// Combinational 5x5 multiply-accumulate.
// Pixels are unsigned and weights are two's complement; tap t sits MSB-first in each vector.
module conv_5x5_mac
  import cnn_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int W_W   = W_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [KER*KER*IN_W-1:0] pix,
  input  logic [KER*KER*W_W-1:0]  wt,
  output logic [ACC_W-1:0]        sum
);

  localparam int NTAP = KER * KER;

  logic signed [ACC_W-1:0] acc_s;
  logic signed [ACC_W-1:0] px_s;
  logic signed [ACC_W-1:0] wx_s;

  // Sum of 25 products; pixel gets a zero sign bit so it stays non-negative.
  always_comb begin
    acc_s = '0;
    px_s  = '0;
    wx_s  = '0;
    for (int t = 0; t < NTAP; t++) begin
      px_s  = ACC_W'($signed({1'b0, pix[(NTAP-1-t)*IN_W +: IN_W]}));
      wx_s  = ACC_W'($signed(wt[(NTAP-1-t)*W_W +: W_W]));
      acc_s = acc_s + px_s * wx_s;
    end
  end

  assign sum = acc_s;

endmodule

// File: rtl/conv_12_8.sv
// 5x5 valid convolution of a 12x12 map into an 8x8 map, one output pixel per cycle.
// Define CONV_12_8_RELU_EN to clamp negative sums to zero before they are buffered.
module conv_12_8
  import cnn_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int W_W   = W_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start_flag,
  input  logic [MAP_IN*MAP_IN*IN_W-1:0]    in,
  input  logic [KER*KER*W_W-1:0]           weight,
  output logic [MAP_OUT*MAP_OUT*ACC_W-1:0] out,
  output logic                             end_flag,
  output logic                             busy
);

  localparam int NPIX_IN  = MAP_IN * MAP_IN;
  localparam int NPIX_OUT = MAP_OUT * MAP_OUT;
  localparam int NTAP     = KER * KER;
  localparam int CW       = $clog2(MAP_OUT);

  state_t                      state_r, state_nxt_s;
  logic [CW-1:0]               row_r, col_r;
  logic [NPIX_IN*IN_W-1:0]     in_r;
  logic [NTAP*W_W-1:0]         w_r;
  logic [NPIX_OUT*ACC_W-1:0]   buf_r, out_r;
  logic                        end_r;
  logic [NTAP*IN_W-1:0]        win_s;
  logic [ACC_W-1:0]            sum_s, pix_s;
  logic                        last_s;

  assign last_s = (row_r == CW'(MAP_OUT-1)) && (col_r == CW'(MAP_OUT-1));

  // Select the 5x5 window whose top-left corner is (row_r, col_r).
  always_comb begin
    win_s = '0;
    for (int i = 0; i < KER; i++) begin
      for (int j = 0; j < KER; j++) begin
        win_s[(NTAP-1-(i*KER+j))*IN_W +: IN_W] =
          in_r[(NPIX_IN-1-((int'(row_r)+i)*MAP_IN+int'(col_r)+j))*IN_W +: IN_W];
      end
    end
  end

  conv_5x5_mac #(
    .IN_W (IN_W),
    .W_W  (W_W),
    .ACC_W(ACC_W)
  ) u_mac (
    .pix(win_s),
    .wt (w_r),
    .sum(sum_s)
  );

  // Optional ReLU on the freshly computed pixel.
  always_comb begin
    pix_s = sum_s;
`ifdef CONV_12_8_RELU_EN
    if (sum_s[ACC_W-1]) begin
      pix_s = '0;
    end else begin
      pix_s = sum_s;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: start is only honoured in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_flag) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Operand latch, raster counters, pixel buffer and output publish.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_r  <= '0;
      w_r   <= '0;
      row_r <= '0;
      col_r <= '0;
      buf_r <= '0;
      out_r <= '0;
      end_r <= 1'b0;
    end else begin
      end_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_flag) begin
            in_r  <= in;
            w_r   <= weight;
            row_r <= '0;
            col_r <= '0;
          end
        end
        ST_RUN: begin
          buf_r[(NPIX_OUT-1-int'({row_r, col_r}))*ACC_W +: ACC_W] <= pix_s;
          if (col_r == CW'(MAP_OUT-1)) begin
            col_r <= '0;
            row_r <= row_r + CW'(1);
          end else begin
            col_r <= col_r + CW'(1);
          end
          // The last pixel lands in the LSB slot, so splice it in directly.
          if (last_s) begin
            out_r <= {buf_r[NPIX_OUT*ACC_W-1:ACC_W], pix_s};
            end_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out      = out_r;
  assign end_flag = end_r;
  assign busy     = (state_r == ST_RUN);

endmodule

// File: tb/tb_conv_12_8.sv
// Scoreboard bench for conv_12_8: stimulus pushes model results, a monitor checks each end_flag.
// Honours CONV_12_8_RELU_EN when the bench is built with it.
module tb_conv_12_8;

  logic         clk;
  logic         reset;
  logic         start_flag;
  logic [575:0] in_v;
  logic [99:0]  wt_v;
  logic [831:0] out_v;
  logic         end_v;
  logic         busy_v;

  conv_12_8 dut (
    .clk       (clk),
    .reset     (reset),
    .start_flag(start_flag),
    .in        (in_v),
    .weight    (wt_v),
    .out       (out_v),
    .end_flag  (end_v),
    .busy      (busy_v)
  );

  typedef struct {
    logic [831:0] o;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   passes = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [831:0] act, input logic [831:0] req);
    checks++;
    if (act !== req) begin
      $display("FAIL %s: got %h want %h", nm, act, req);
    end else begin
      passes++;
    end
  endtask

  // Reference: plain integer convolution over 2-D arrays.
  function automatic logic [831:0] model(input logic [575:0] im, input logic [99:0] wk);
    int p[12][12];
    int w[5][5];
    int s;
    logic [31:0] sv;
    logic [831:0] res;
    logic [3:0] nib;
    res = '0;
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 12; c++) begin
        nib = im[575-(r*12+c)*4 -: 4];
        p[r][c] = int'(nib);
      end
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        nib = wk[99-(i*5+j)*4 -: 4];
        w[i][j] = int'($signed(nib));
      end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        s = 0;
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++)
            s += p[r+i][c+j] * w[i][j];
`ifdef CONV_12_8_RELU_EN
        if (s < 0) s = 0;
`endif
        sv = s;
        res[831-(r*8+c)*13 -: 13] = sv[12:0];
      end
    return res;
  endfunction

  function automatic logic [575:0] fill_map(input logic [3:0] v);
    logic [575:0] m;
    for (int k = 0; k < 144; k++) m[575-k*4 -: 4] = v;
    return m;
  endfunction

  function automatic logic [99:0] fill_ker(input logic [3:0] v);
    logic [99:0] m;
    for (int k = 0; k < 25; k++) m[99-k*4 -: 4] = v;
    return m;
  endfunction

  // Called at a negedge; the start is sampled at the next rising edge (E0).
  task automatic launch(input logic [575:0] im, input logic [99:0] wk,
                        input bit expect_done, output int e0);
    exp_t e;
    in_v       = im;
    wt_v       = wk;
    start_flag = 1'b1;
    e0         = cyc + 1;
    if (expect_done) begin
      e.o   = model(im, wk);
      e.cyc = e0 + 64;
      q.push_back(e);
    end
    @(negedge clk);
    start_flag = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: every end_flag must match the oldest expected result and its cycle.
  always @(negedge clk) begin
    if (reset && end_v) begin
      if (q.size() == 0) begin
        chk("unexpected_end", 832'(end_v), 832'(1'b0));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", out_v, e.o);
        chk("end_cycle", 832'(cyc), 832'(e.cyc));
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int e0, e1;
    logic [575:0] im, im2;
    logic [99:0]  wk, wk2;
    logic [831:0] first_exp;

    reset      = 1'b0;
    start_flag = 1'b0;
    in_v       = '0;
    wt_v       = '0;
    repeat (3) @(negedge clk);
    chk("reset_out", out_v, '0);
    chk("reset_end", 832'(end_v), 832'(1'b0));
    chk("reset_busy", 832'(busy_v), 832'(1'b0));
    reset = 1'b1;
    @(negedge clk);

    // Identity tap at (2,2) on an all-ones map.
    wk = '0;
    wk[99-12*4 -: 4] = 4'd1;
    launch(fill_map(4'd1), wk, 1'b1, e0);
    chk("busy_e1", 832'(busy_v), 832'(1'b1));
    wait_until(e0 + 63);
    chk("busy_e63", 832'(busy_v), 832'(1'b1));
    wait_until(e0 + 64);
    chk("busy_e64", 832'(busy_v), 832'(1'b0));
    chk("ident_px0", 832'(out_v[831 -: 13]), 832'(13'd1));
    @(negedge clk);

    // Most negative corner.
    launch(fill_map(4'd15), fill_ker(4'b1000), 1'b1, e0);
    wait_until(e0 + 64);
`ifdef CONV_12_8_RELU_EN
    chk("neg_px63", 832'(out_v[12:0]), 832'(13'd0));
`else
    chk("neg_px63", 832'(out_v[12:0]), 832'(13'h1448));
`endif

    // Most positive corner.
    launch(fill_map(4'd15), fill_ker(4'd7), 1'b1, e0);
    wait_until(e0 + 64);
    chk("pos_px63", 832'(out_v[12:0]), 832'(13'd2625));

    // Ramp map, tap (0,0) only.
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 12; c++) im[575-(r*12+c)*4 -: 4] = 4'((r + c) % 16);
    wk = '0;
    wk[99 -: 4] = 4'd1;
    launch(im, wk, 1'b1, e0);
    wait_until(e0 + 64);
    chk("ramp_px63", 832'(out_v[12:0]), 832'(13'd14));

    // Start during RUN with different data must be ignored.
    im = fill_map(4'd3);
    wk = fill_ker(4'd2);
    launch(im, wk, 1'b1, e0);
    wait_until(e0 + 9);
    launch(fill_map(4'd9), fill_ker(4'b1101), 1'b0, e1);
    wait_until(e0 + 70);

    // Reset in the middle of a run.
    launch(fill_map(4'd5), fill_ker(4'd1), 1'b0, e0);
    wait_until(e0 + 29);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_out", out_v, '0);
    chk("abort_busy", 832'(busy_v), 832'(1'b0));
    chk("abort_end", 832'(end_v), 832'(1'b0));
    reset = 1'b1;
    repeat (70) @(negedge clk);
    launch(fill_map(4'd2), fill_ker(4'd3), 1'b1, e0);
    wait_until(e0 + 64);
    @(negedge clk);

    // Back-to-back: second start in the end_flag cycle.
    im  = fill_map(4'd4);
    wk  = fill_ker(4'b1111);
    im2 = fill_map(4'd6);
    wk2 = fill_ker(4'd1);
    first_exp = model(im, wk);
    launch(im, wk, 1'b1, e0);
    wait_until(e0 + 64);
    launch(im2, wk2, 1'b1, e1);
    wait_until(e0 + 128);
    chk("hold_first", out_v, first_exp);
    wait_until(e1 + 64);

    // Randomised transactions with small idle gaps.
    for (int n = 0; n < 5; n++) begin
      for (int k = 0; k < 18; k++) im[k*32 +: 32] = $urandom;
      for (int k = 0; k < 4; k++) wk[k*25 +: 25] = 25'($urandom);
      launch(im, wk, 1'b1, e0);
      wait_until(e0 + 64);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    for (int k = 0; k < 100 && q.size() > 0; k++) @(negedge clk);
    chk("queue_drained", 832'(q.size()), 832'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
